// File: rtl/matmul_cmd_scheduler_pkg.sv
// Shared types for the matmul command scheduler.
//   matmul_cmd_t  : host command word, LSB = v_dim
//   sched_state_e : scheduler FSM states
//   has_zero_dim  : true if any operand dimension of a command is zero
package matmul_cmd_scheduler_pkg;

  localparam int unsigned DIM_W     = 7;
  localparam int unsigned UB_ADDR_W = 12;
  localparam int unsigned CMD_W     = UB_ADDR_W + 3 * DIM_W;

  typedef struct packed {
    logic [UB_ADDR_W-1:0] ub_addr;
    logic [DIM_W-1:0]     iter_dim;
    logic [DIM_W-1:0]     u_dim;
    logic [DIM_W-1:0]     v_dim;
  } matmul_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StBusy,
    StDone,
    StHalt
  } sched_state_e;

  function automatic logic has_zero_dim(matmul_cmd_t cmd);
    return (cmd.v_dim == '0) || (cmd.u_dim == '0) || (cmd.iter_dim == '0);
  endfunction

endpackage

// File: rtl/matmul_cmd_scheduler_fifo.sv
// Synchronous FIFO holding pending commands.
//   clk_i, rst_i      : clock, synchronous active-low reset
//   push_i, data_i    : write request and data (ignored while full)
//   pop_i, data_o     : read request (ignored while empty) and head entry
//   count_o           : occupancy; full_o / empty_o flags
// Same-cycle push and pop leave the count unchanged. Depth must be a power of two,
// so the pointers wrap for free.
module cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  T                 mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/matmul_cmd_scheduler.sv
// Matmul command scheduler: buffers host commands and issues them one at a time
// to the control path, waiting for done_i between commands.
//   cmd_valid_i/cmd_i/cmd_ready_o : host command handshake
//   instruction_o + operand outputs : single-cycle issue pulse, operands held stable
//   done_i                       : datapath completion (only honoured while busy)
//   clear_i                      : clears err_o/timeout_o, releases the halt state
//   status: busy_o, cmd_done_o, cmds_completed_o, cmds_dropped_o, fifo_count_o,
//           err_o (zero-dim command dropped), timeout_o (watchdog fired)
module matmul_cmd_scheduler
  import matmul_cmd_scheduler_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  input  logic [CMD_W-1:0]             cmd_i,
  output logic                         cmd_ready_o,
  input  logic                         done_i,
  input  logic                         clear_i,
  output logic                         instruction_o,
  output logic [DIM_W-1:0]             V_dim_o,
  output logic [DIM_W-1:0]             U_dim_o,
  output logic [DIM_W-1:0]             ITER_dim_o,
  output logic [DIM_W-1:0]             V_dim1_o,
  output logic [DIM_W-1:0]             U_dim1_o,
  output logic [DIM_W-1:0]             ITER_dim1_o,
  output logic [UB_ADDR_W-1:0]         ub_start_addr_o,
  output logic                         busy_o,
  output logic                         cmd_done_o,
  output logic [15:0]                  cmds_completed_o,
  output logic [7:0]                   cmds_dropped_o,
  output logic [$clog2(CMD_DEPTH):0]   fifo_count_o,
  output logic                         err_o,
  output logic                         timeout_o
);

  localparam int unsigned WdW = 20;

  sched_state_e      state_q, state_d;
  matmul_cmd_t       head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  matmul_cmd_t       op_q, op_d;
  logic [DIM_W-1:0]  v1_q, v1_d, u1_q, u1_d, it1_q, it1_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              err_q, err_d, tmo_q, tmo_d;
  logic [15:0]       completed_q, completed_d;
  logic [7:0]        dropped_q, dropped_d;

  assign cmd_ready_o = rst_i & ~fifo_full;
  assign fifo_push   = cmd_valid_i & cmd_ready_o;

  cmd_fifo #(
    .Depth (CMD_DEPTH),
    .T     (matmul_cmd_t)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (matmul_cmd_t'(cmd_i)),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .count_o (fifo_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    v1_d          = v1_q;
    u1_d          = u1_q;
    it1_d         = it1_q;
    wd_d          = wd_q;
    err_d         = err_q & ~clear_i;
    tmo_d         = tmo_q & ~clear_i;
    completed_d   = completed_q;
    dropped_d     = dropped_q;
    fifo_pop      = 1'b0;
    instruction_o = 1'b0;
    busy_o        = 1'b0;
    cmd_done_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (has_zero_dim(head)) begin
            // Rejected commands never touch the operand registers.
            err_d = 1'b1;
            if (dropped_q != 8'hff) dropped_d = dropped_q + 8'd1;
          end else begin
            op_d    = head;
            v1_d    = head.v_dim - DIM_W'(1);
            u1_d    = head.u_dim - DIM_W'(1);
            it1_d   = head.iter_dim - DIM_W'(1);
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        instruction_o = 1'b1;
        busy_o        = 1'b1;
        wd_d          = '0;
        state_d       = StBusy;
      end
      StBusy: begin
        busy_o = 1'b1;
        // done_i has priority over a watchdog expiry in the same cycle.
        if (done_i) begin
          state_d = StDone;
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = StHalt;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StDone: begin
        busy_o      = 1'b1;
        cmd_done_o  = 1'b1;
        completed_d = completed_q + 16'd1;
        state_d     = StIdle;
      end
      StHalt: begin
        if (clear_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      op_q        <= '0;
      v1_q        <= '0;
      u1_q        <= '0;
      it1_q       <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      completed_q <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      v1_q        <= v1_d;
      u1_q        <= u1_d;
      it1_q       <= it1_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      completed_q <= completed_d;
      dropped_q   <= dropped_d;
    end
  end

  assign V_dim_o          = op_q.v_dim;
  assign U_dim_o          = op_q.u_dim;
  assign ITER_dim_o       = op_q.iter_dim;
  assign ub_start_addr_o  = op_q.ub_addr;
  assign V_dim1_o         = v1_q;
  assign U_dim1_o         = u1_q;
  assign ITER_dim1_o      = it1_q;
  assign cmds_completed_o = completed_q;
  assign cmds_dropped_o   = dropped_q;
  assign err_o            = err_q;
  assign timeout_o        = tmo_q;

endmodule

// File: tb/tb_matmul_cmd_scheduler.sv
// Bench for matmul_cmd_scheduler: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the scheduler's rules.
module tb_matmul_cmd_scheduler;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 16;

  logic        clk;
  logic        rst_i, cmd_valid_i, done_i, clear_i;
  logic [32:0] cmd_i;
  logic        cmd_ready_o, instruction_o, busy_o, cmd_done_o, err_o, timeout_o;
  logic [6:0]  V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o, ITER_dim1_o;
  logic [11:0] ub_start_addr_o;
  logic [15:0] cmds_completed_o;
  logic [7:0]  cmds_dropped_o;
  logic [2:0]  fifo_count_o;

  matmul_cmd_scheduler #(
    .CMD_DEPTH      (Depth),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_i            (cmd_i),
    .cmd_ready_o      (cmd_ready_o),
    .done_i           (done_i),
    .clear_i          (clear_i),
    .instruction_o    (instruction_o),
    .V_dim_o          (V_dim_o),
    .U_dim_o          (U_dim_o),
    .ITER_dim_o       (ITER_dim_o),
    .V_dim1_o         (V_dim1_o),
    .U_dim1_o         (U_dim1_o),
    .ITER_dim1_o      (ITER_dim1_o),
    .ub_start_addr_o  (ub_start_addr_o),
    .busy_o           (busy_o),
    .cmd_done_o       (cmd_done_o),
    .cmds_completed_o (cmds_completed_o),
    .cmds_dropped_o   (cmds_dropped_o),
    .fifo_count_o     (fifo_count_o),
    .err_o            (err_o),
    .timeout_o        (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending queue, an in-flight command aged in cycles since its pop,
  // a one-cycle completion gap, and a halt flag.
  logic [32:0] mq[$];
  bit          m_inflight, m_fin, m_halt, m_err, m_tmo, m_pushed;
  int          m_age;
  logic [32:0] m_ops;
  logic [20:0] m_ops1;
  int          m_completed, m_dropped;

  function automatic bit zero_dim(logic [32:0] c);
    return (c[6:0] == 0) || (c[13:7] == 0) || (c[20:14] == 0);
  endfunction

  task automatic model_edge();
    bit          idle, pop, push;
    logic [32:0] c;
    m_pushed = 0;
    if (!rst_i) begin
      mq.delete();
      m_inflight = 0; m_fin = 0; m_halt = 0; m_err = 0; m_tmo = 0;
      m_age = 0; m_ops = '0; m_ops1 = '0; m_completed = 0; m_dropped = 0;
      return;
    end
    idle = !m_inflight && !m_fin && !m_halt;
    pop  = idle && (mq.size() > 0);
    push = cmd_valid_i && (mq.size() < Depth);
    if (clear_i) begin
      m_err = 0;
      m_tmo = 0;
    end
    if (m_fin) begin
      m_fin       = 0;
      m_completed = (m_completed + 1) % 65536;
    end else if (m_inflight) begin
      // age 0 = issue cycle; age k>=1 = k-th busy cycle (watchdog value k-1)
      if (m_age == 0) m_age = 1;
      else if (done_i) begin
        m_inflight = 0;
        m_fin      = 1;
      end else if (m_age == Tmo) begin
        m_inflight = 0;
        m_halt     = 1;
        m_tmo      = 1;
      end else m_age++;
    end else if (m_halt && clear_i) begin
      m_halt = 0;
    end
    if (pop) begin
      c = mq.pop_front();
      if (zero_dim(c)) begin
        m_err = 1;
        if (m_dropped < 255) m_dropped++;
      end else begin
        m_ops      = c;
        m_ops1     = {c[20:14] - 7'd1, c[13:7] - 7'd1, c[6:0] - 7'd1};
        m_inflight = 1;
        m_age      = 0;
      end
    end
    if (push) begin
      mq.push_back(cmd_i);
      m_pushed = 1;
    end
  endtask

  task automatic compare_all();
    check_val("instr", instruction_o, m_inflight && (m_age == 0));
    check_val("busy", busy_o, m_inflight || m_fin);
    check_val("cmd_done", cmd_done_o, m_fin);
    check_val("ready", cmd_ready_o, rst_i && (mq.size() < Depth));
    check_val("count", fifo_count_o, mq.size());
    check_val("err", err_o, m_err);
    check_val("timeout", timeout_o, m_tmo);
    check_val("completed", cmds_completed_o, m_completed);
    check_val("dropped", cmds_dropped_o, m_dropped);
    check_val("ops", {ub_start_addr_o, ITER_dim_o, U_dim_o, V_dim_o}, m_ops);
    check_val("dims1", {ITER_dim1_o, U_dim1_o, V_dim1_o}, m_ops1);
  endtask

  // Stimulus bookkeeping (drives done_i and gathers scenario statistics).
  int          done_mode = 0;  // 0 manual, 1 done 3 cycles after issue, 2 random
  int          done_prob = 0;
  int          since_issue = 100;
  int          cyc_no = 0;
  int          last_instr = -1;
  int          min_gap = 1000;
  int          n_instr = 0;
  bit          saw_not_ready = 0;
  logic [11:0] issued[$];

  task automatic cyc();
    if (done_mode == 1) done_i = (since_issue == 3);
    else if (done_mode == 2) done_i = ($urandom_range(99) < done_prob);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cyc_no++;
    if (rst_i && !cmd_ready_o) saw_not_ready = 1;
    if (instruction_o === 1'b1) begin
      since_issue = 0;
      if (last_instr >= 0 && (cyc_no - last_instr) < min_gap) min_gap = cyc_no - last_instr;
      last_instr = cyc_no;
      n_instr++;
      issued.push_back(ub_start_addr_o);
    end else begin
      since_issue++;
    end
  endtask

  function automatic logic [32:0] mk(int v, int u, int it, int a);
    return {12'(a), 7'(it), 7'(u), 7'(v)};
  endfunction

  task automatic push_cmd(input logic [32:0] c);
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (m_pushed) break;
    end
    if (!m_pushed) check_val("push_wait", 0, 1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_instr(input string tag);
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (instruction_o === 1'b1) break;
    end
    if (instruction_o !== 1'b1) check_val({tag, "_wait"}, 0, 1);
  endtask

  task automatic reset_stats();
    n_instr = 0;
    min_gap = 1000;
    last_instr = -1;
    saw_not_ready = 0;
    issued.delete();
  endtask

  int base_c, base_d;

  initial begin
    rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_i = '0; done_i = 1'b0; clear_i = 1'b0;

    // Reset state
    cyc(); cyc();
    check_val("rst_ready", cmd_ready_o, 0);
    check_val("rst_count", fifo_count_o, 0);
    check_val("rst_busy", busy_o, 0);
    rst_i = 1'b1;
    cyc();

    // Single command: latency and operands
    push_cmd(mk(4, 3, 2, 'h010));
    check_val("t1_no_instr_yet", instruction_o, 0);
    cyc();
    check_val("t1_instr", instruction_o, 1);
    check_val("t1_v1", V_dim1_o, 3);
    check_val("t1_u1", U_dim1_o, 2);
    check_val("t1_it1", ITER_dim1_o, 1);
    check_val("t1_addr", ub_start_addr_o, 'h010);
    cyc();
    check_val("t1_instr_single", instruction_o, 0);
    repeat (3) cyc();
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    check_val("t1_cmd_done", cmd_done_o, 1);
    cyc();
    check_val("t1_completed", cmds_completed_o, 1);

    // Burst of six with auto done
    reset_stats();
    base_c = cmds_completed_o;
    done_mode = 1;
    for (int i = 0; i < 6; i++)
      push_cmd(mk($urandom_range(127, 1), $urandom_range(127, 1), $urandom_range(127, 1),
                  'h100 + i));
    repeat (60) cyc();
    check_val("t2_completed", 16'(cmds_completed_o - 16'(base_c)), 6);
    check_val("t2_instr_cnt", n_instr, 6);
    check_val("t2_ready_dropped", saw_not_ready, 1);
    check_val("t2_gap_ge3", (min_gap >= 3), 1);
    for (int i = 0; i < 6; i++)
      check_val("t2_order", (i < issued.size()) ? issued[i] : 12'hfff, 'h100 + i);

    // Zero-dim reject between two good commands
    reset_stats();
    base_d = cmds_dropped_o;
    push_cmd(mk(5, 5, 5, 'h200));
    push_cmd(mk(5, 0, 5, 'h201));
    push_cmd(mk(6, 6, 6, 'h202));
    repeat (40) cyc();
    check_val("t3_instr_cnt", n_instr, 2);
    check_val("t3_err", err_o, 1);
    check_val("t3_dropped", cmds_dropped_o - 8'(base_d), 1);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check_val("t3_err_clr", err_o, 0);

    // Watchdog expiry, halt, clear releases the queued command
    done_mode = 0; done_i = 1'b0;
    push_cmd(mk(2, 2, 2, 'h300));
    wait_instr("t4_a");
    push_cmd(mk(3, 3, 3, 'h301));
    repeat (15) cyc();
    check_val("t4_tmo_early", timeout_o, 0);
    cyc();
    check_val("t4_tmo", timeout_o, 1);
    reset_stats();
    repeat (5) cyc();
    check_val("t4_no_issue", n_instr, 0);
    check_val("t4_queued", fifo_count_o, 1);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check_val("t4_tmo_clr", timeout_o, 0);
    check_val("t4_instr_wait", instruction_o, 0);
    cyc();
    check_val("t4_instr", instruction_o, 1);
    check_val("t4_addr", ub_start_addr_o, 'h301);
    done_mode = 1;
    repeat (10) cyc();

    // done_i coincident with watchdog expiry
    done_mode = 0; done_i = 1'b0;
    push_cmd(mk(7, 7, 7, 'h400));
    wait_instr("t5");
    repeat (16) cyc();
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    check_val("t5_done", cmd_done_o, 1);
    check_val("t5_tmo", timeout_o, 0);
    repeat (3) cyc();

    // Reset while busy with two queued
    push_cmd(mk(1, 2, 3, 'h500));
    wait_instr("t6");
    push_cmd(mk(4, 5, 6, 'h501));
    push_cmd(mk(7, 8, 9, 'h502));
    cyc();
    check_val("t6_busy", busy_o, 1);
    check_val("t6_queued", fifo_count_o, 2);
    rst_i = 1'b0;
    cyc();
    check_val("t6_ready_in_rst", cmd_ready_o, 0);
    rst_i = 1'b1;
    check_val("t6_busy0", busy_o, 0);
    check_val("t6_count0", fifo_count_o, 0);
    check_val("t6_completed0", cmds_completed_o, 0);
    check_val("t6_addr0", ub_start_addr_o, 0);
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    check_val("t6_late_done", cmd_done_o, 0);
    repeat (3) cyc();

    // Random traffic
    done_mode = 2;
    for (int seg = 0; seg < 15; seg++) begin
      case ($urandom_range(2))
        0: done_prob = 0;
        1: done_prob = 8;
        default: done_prob = 40;
      endcase
      for (int i = 0; i < 200; i++) begin
        logic [6:0] v, u, it;
        v  = ($urandom_range(7) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
        u  = ($urandom_range(7) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
        it = ($urandom_range(7) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
        cmd_valid_i = ($urandom_range(99) < 50);
        cmd_i       = {12'($urandom), it, u, v};
        clear_i     = ($urandom_range(99) < 3);
        rst_i       = ($urandom_range(499) != 0);
        cyc();
      end
    end
    cmd_valid_i = 1'b0; clear_i = 1'b0; rst_i = 1'b1; done_mode = 0; done_i = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
